// File: rtl/probe_pkg.sv
// Shared types for the probe poll master: FSM states,
// detector register map and AXI response codes.
package probe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_AR,
    S_CFG_R,
    S_SMP_AR,
    S_SMP_R,
    S_PUSH,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [2:0] REG_RESULT = 3'h0;
  localparam logic [2:0] REG_CONFIG = 3'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/probe_poll_master_if.sv
// AXI4-Lite read channels plus the sample result stream
// between the poll master and its neighbours.
interface probe_poll_master_if #(
  parameter int M_AXI_ADDR_WIDTH = 3,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int PROBE_WIDTH      = 14,
  parameter int NSAMP_WIDTH      = 16
);

  logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_araddr;
  logic [2:0]                  M_AXI_arprot;
  logic                        M_AXI_arvalid;
  logic                        M_AXI_arready;
  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_rdata;
  logic [1:0]                  M_AXI_rresp;
  logic                        M_AXI_rvalid;
  logic                        M_AXI_rready;

  logic                        res_valid;
  logic                        res_ready;
  logic [PROBE_WIDTH-1:0]      res_data;
  logic [NSAMP_WIDTH-1:0]      res_index;

  modport master (
    output M_AXI_araddr,
    output M_AXI_arprot,
    output M_AXI_arvalid,
    input  M_AXI_arready,
    input  M_AXI_rdata,
    input  M_AXI_rresp,
    input  M_AXI_rvalid,
    output M_AXI_rready,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_index
  );

  modport slave (
    input  M_AXI_araddr,
    input  M_AXI_arprot,
    input  M_AXI_arvalid,
    output M_AXI_arready,
    output M_AXI_rdata,
    output M_AXI_rresp,
    output M_AXI_rvalid,
    input  M_AXI_rready,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_index
  );

endinterface

// File: rtl/probe_stats_acc.sv
// Running saturating sum and unsigned min/max of the
// samples collected during one poll run.
module probe_stats_acc #(
  parameter int PROBE_WIDTH = 14,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   upd,
  input  logic [PROBE_WIDTH-1:0] smp,
  output logic [SUM_WIDTH-1:0]   sum,
  output logic [PROBE_WIDTH-1:0] min_val,
  output logic [PROBE_WIDTH-1:0] max_val
);

  logic [SUM_WIDTH:0] sum_ext;

  // One spare bit catches the carry that triggers saturation.
  assign sum_ext = (SUM_WIDTH+1)'(sum)
                 + (SUM_WIDTH+1)'(smp);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum     <= '0;
      min_val <= '1;
      max_val <= '0;
    end else if (upd) begin
      if (sum_ext[SUM_WIDTH])
        sum <= '1;
      else
        sum <= sum_ext[SUM_WIDTH-1:0];
      if (smp < min_val)
        min_val <= smp;
      if (smp > max_val)
        max_val <= smp;
    end
  end

endmodule

// File: rtl/probe_poll_master.sv
// AXI4-Lite read master: reads the averaging window once, then
// polls the probe count N times and streams each sample out.
module probe_poll_master
  import probe_pkg::*;
#(
  parameter int M_AXI_ADDR_WIDTH = 3,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int PROBE_WIDTH      = 14,
  parameter logic [M_AXI_ADDR_WIDTH-1:0] RESULT_ADDR =
    M_AXI_ADDR_WIDTH'(REG_RESULT),
  parameter logic [M_AXI_ADDR_WIDTH-1:0] CONFIG_ADDR =
    M_AXI_ADDR_WIDTH'(REG_CONFIG),
  parameter int NSAMP_WIDTH      = 16,
  parameter int SUM_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                        M_AXI_aclk,
  input  logic                        M_AXI_areset,
  input  logic                        start,
  input  logic [NSAMP_WIDTH-1:0]      num_samples,
  output logic                        busy,
  output logic                        done,
  output logic                        err_resp,
  output logic                        err_timeout,
  output logic [M_AXI_DATA_WIDTH-1:0] aver_time,
  output logic [SUM_WIDTH-1:0]        sum,
  output logic [PROBE_WIDTH-1:0]      min_val,
  output logic [PROBE_WIDTH-1:0]      max_val,
  probe_poll_master_if.master         m
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [NSAMP_WIDTH-1:0] nsamp;
  logic [NSAMP_WIDTH-1:0] idx_nxt;
  logic [TW-1:0]          tcnt;
  logic [PROBE_WIDTH-1:0] smp;
  logic                   resp_ok;
  logic                   st_clr;
  logic                   st_upd;

  assign m.M_AXI_arprot = 3'b000;

  assign smp     = m.M_AXI_rdata[PROBE_WIDTH-1:0];
  assign resp_ok = (m.M_AXI_rresp == RESP_OKAY);
  assign idx_nxt = m.res_index + NSAMP_WIDTH'(1);
  assign st_clr  = (state == S_IDLE) && start;
  assign st_upd  = (state == S_SMP_R)
                && m.M_AXI_rvalid && resp_ok;

  probe_stats_acc #(
    .PROBE_WIDTH (PROBE_WIDTH),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_stats (
    .clk     (M_AXI_aclk),
    .rst     (M_AXI_areset),
    .clr     (st_clr),
    .upd     (st_upd),
    .smp     (smp),
    .sum     (sum),
    .min_val (min_val),
    .max_val (max_val)
  );

  always_ff @(posedge M_AXI_aclk) begin
    if (M_AXI_areset) begin
      state           <= S_IDLE;
      nsamp           <= '0;
      tcnt            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_resp        <= 1'b0;
      err_timeout     <= 1'b0;
      aver_time       <= '0;
      m.M_AXI_araddr  <= '0;
      m.M_AXI_arvalid <= 1'b0;
      m.M_AXI_rready  <= 1'b0;
      m.res_valid     <= 1'b0;
      m.res_data      <= '0;
      m.res_index     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nsamp           <= num_samples;
            err_resp        <= 1'b0;
            err_timeout     <= 1'b0;
            busy            <= 1'b1;
            m.res_index     <= '0;
            m.M_AXI_araddr  <= CONFIG_ADDR;
            m.M_AXI_arvalid <= 1'b1;
            state           <= S_CFG_AR;
          end
        end
        S_CFG_AR, S_SMP_AR: begin
          if (m.M_AXI_arready) begin
            m.M_AXI_arvalid <= 1'b0;
            m.M_AXI_rready  <= 1'b1;
            tcnt            <= '0;
            state <= (state == S_CFG_AR) ? S_CFG_R : S_SMP_R;
          end
        end
        S_CFG_R: begin
          if (m.M_AXI_rvalid) begin
            aver_time      <= m.M_AXI_rdata;
            m.M_AXI_rready <= 1'b0;
            if (!resp_ok || nsamp == '0) begin
              err_resp <= !resp_ok;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else begin
              m.M_AXI_araddr  <= RESULT_ADDR;
              m.M_AXI_arvalid <= 1'b1;
              state           <= S_SMP_AR;
            end
          end else if (tcnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_DRAIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_SMP_R: begin
          if (m.M_AXI_rvalid) begin
            m.M_AXI_rready <= 1'b0;
            if (!resp_ok) begin
              err_resp <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FIN;
            end else begin
              m.res_data  <= smp;
              m.res_valid <= 1'b1;
              state       <= S_PUSH;
            end
          end else if (tcnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_DRAIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_PUSH: begin
          // Next AR waits for the consumer, so backpressure
          // stalls the bus rather than buffering samples.
          if (m.res_ready) begin
            m.res_valid <= 1'b0;
            m.res_index <= idx_nxt;
            if (idx_nxt == nsamp) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              m.M_AXI_araddr  <= RESULT_ADDR;
              m.M_AXI_arvalid <= 1'b1;
              state           <= S_SMP_AR;
            end
          end
        end
        S_DRAIN: begin
          if (m.M_AXI_rvalid) begin
            m.M_AXI_rready <= 1'b0;
            done           <= 1'b1;
            busy           <= 1'b0;
            state          <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_probe_poll_master.sv
// Directed bench for probe_poll_master against a small
// registered AXI read slave with per-sample latency.
`define CHK(tag, obs, exp) \
  begin \
    tests++; \
    assert ((obs) === (exp)) else begin \
      fails++; \
      $error("FAIL %s: observed %0d expected %0d", \
             tag, (obs), (exp)); \
    end \
  end

module tb_probe_poll_master;
  import probe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        busy, done, err_resp, err_timeout;
  logic [31:0] aver_time;
  logic [31:0] sum;
  logic [13:0] min_val, max_val;

  int tests = 0;
  int fails = 0;

  probe_poll_master_if bus ();

  probe_poll_master #(
    .TIMEOUT_CYCLES (600)
  ) dut (
    .M_AXI_aclk   (clk),
    .M_AXI_areset (rst),
    .start        (start),
    .num_samples  (num_samples),
    .busy         (busy),
    .done         (done),
    .err_resp     (err_resp),
    .err_timeout  (err_timeout),
    .aver_time    (aver_time),
    .sum          (sum),
    .min_val      (min_val),
    .max_val      (max_val),
    .m            (bus)
  );

  always #5 clk = ~clk;

  // slave model
  logic        ar_always = 1'b1;
  int          ar_wait = 0;
  logic        arready_q;
  logic [31:0] cfg_val = 0;
  logic [31:0] smp_data [4];
  logic [1:0]  smp_resp [4];
  int          smp_wait [4];
  logic [1:0]  smp_i;
  int          ph, cnt, rw_cur;

  assign bus.M_AXI_arready = ar_always | arready_q;

  always @(posedge clk) begin
    int w;
    if (rst) begin
      arready_q        <= 1'b0;
      bus.M_AXI_rvalid <= 1'b0;
      bus.M_AXI_rdata  <= '0;
      bus.M_AXI_rresp  <= '0;
      ph     <= 0;
      cnt    <= 0;
      rw_cur <= 0;
      smp_i  <= '0;
    end else begin
      if (start) smp_i <= '0;
      case (ph)
        0: begin
          if (bus.M_AXI_arvalid && bus.M_AXI_arready) begin
            arready_q <= 1'b0;
            if (bus.M_AXI_araddr == REG_CONFIG) begin
              bus.M_AXI_rdata <= cfg_val;
              bus.M_AXI_rresp <= RESP_OKAY;
              w = 0;
            end else begin
              bus.M_AXI_rdata <= smp_data[smp_i];
              bus.M_AXI_rresp <= smp_resp[smp_i];
              w = smp_wait[smp_i];
              smp_i <= smp_i + 2'd1;
            end
            rw_cur <= w;
            if (w == 0) begin
              bus.M_AXI_rvalid <= 1'b1;
              cnt <= 0;
              ph  <= 2;
            end else begin
              cnt <= 1;
              ph  <= 1;
            end
          end else if (bus.M_AXI_arvalid) begin
            if (cnt >= ar_wait) arready_q <= 1'b1;
            else cnt <= cnt + 1;
          end
        end
        1: begin
          if (cnt >= rw_cur) begin
            bus.M_AXI_rvalid <= 1'b1;
            ph <= 2;
          end else begin
            cnt <= cnt + 1;
          end
        end
        default: begin
          if (bus.M_AXI_rready) begin
            bus.M_AXI_rvalid <= 1'b0;
            cnt <= 0;
            ph  <= 0;
          end
        end
      endcase
    end
  end

  // bus monitor
  logic [2:0]  addr_q [$];
  logic [13:0] dat_q  [$];
  logic [15:0] idx_q  [$];
  int          done_cnt = 0;
  int          overlap = 0;
  int          ar_unstable = 0;
  logic        pend = 1'b0;
  logic [2:0]  pend_addr = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.M_AXI_arvalid && bus.M_AXI_arready)
        addr_q.push_back(bus.M_AXI_araddr);
      if (bus.res_valid && bus.res_ready) begin
        dat_q.push_back(bus.res_data);
        idx_q.push_back(bus.res_index);
      end
      if (done) done_cnt++;
      if (bus.res_valid && bus.M_AXI_arvalid) overlap++;
      if (pend && !(bus.M_AXI_arvalid &&
                    bus.M_AXI_araddr == pend_addr))
        ar_unstable++;
    end
    pend = bus.M_AXI_arvalid && !bus.M_AXI_arready && !rst;
    pend_addr = bus.M_AXI_araddr;
  end

  task automatic kick(input logic [15:0] n_s);
    repeat (2) @(negedge clk);
    num_samples = n_s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input int n0,
                           output int n);
    n = n0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, d0, b0, a0, k, bad;
    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp_data[i] = '0;
      smp_resp[i] = RESP_OKAY;
      smp_wait[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_errs", {err_resp, err_timeout}, 2'b00)
    `CHK("rst_sum", sum, 32'd0)
    `CHK("rst_min", min_val, 14'h3FFF)
    `CHK("rst_max", max_val, 14'd0)
    `CHK("rst_arvalid", bus.M_AXI_arvalid, 1'b0)
    `CHK("rst_rready", bus.M_AXI_rready, 1'b0)
    `CHK("rst_res_valid", bus.res_valid, 1'b0)
    `CHK("rst_aver", aver_time, 32'd0)
    `CHK("arprot", bus.M_AXI_arprot, 3'b000)

    // basic run; upper rdata bits must be ignored
    cfg_val = 32'd10000;
    smp_data[0] = 32'hABC0_0005;
    smp_data[1] = 32'hFFFF_C009;
    smp_data[2] = 32'd3;
    d0 = done_cnt; b0 = dat_q.size(); a0 = addr_q.size();
    kick(16'd3);
    wait_done(200, 0, n);
    `CHK("t1_latency", n, 11)
    @(negedge clk);
    `CHK("t1_beats", dat_q.size() - b0, 3)
    `CHK("t1_d0", dat_q[b0], 14'd5)
    `CHK("t1_d1", dat_q[b0+1], 14'd9)
    `CHK("t1_d2", dat_q[b0+2], 14'd3)
    `CHK("t1_i0", idx_q[b0], 16'd0)
    `CHK("t1_i1", idx_q[b0+1], 16'd1)
    `CHK("t1_i2", idx_q[b0+2], 16'd2)
    `CHK("t1_sum", sum, 32'd17)
    `CHK("t1_min", min_val, 14'd3)
    `CHK("t1_max", max_val, 14'd9)
    `CHK("t1_aver", aver_time, 32'd10000)
    `CHK("t1_done_once", done_cnt - d0, 1)
    `CHK("t1_done_pulse", done, 1'b0)
    `CHK("t1_busy", busy, 1'b0)
    `CHK("t1_nar", addr_q.size() - a0, 4)
    `CHK("t1_a0", addr_q[a0], 3'h4)
    `CHK("t1_a1", addr_q[a0+1], 3'h0)
    `CHK("t1_a3", addr_q[a0+3], 3'h0)

    // zero samples: config read only
    d0 = done_cnt; b0 = dat_q.size(); a0 = addr_q.size();
    kick(16'd0);
    wait_done(100, 0, n);
    `CHK("t2_latency", n, 2)
    @(negedge clk);
    `CHK("t2_beats", dat_q.size() - b0, 0)
    `CHK("t2_nar", addr_q.size() - a0, 1)
    `CHK("t2_done_once", done_cnt - d0, 1)

    // slow slave, AR wait states, consumer stall on beat 1
    ar_always = 1'b0;
    ar_wait = 2;
    cfg_val = 32'd321;
    smp_data[0] = 32'd100;
    smp_data[1] = 32'h0000_3FFF;
    smp_data[2] = 32'd0;
    for (int i = 0; i < 3; i++) smp_wait[i] = 500;
    d0 = done_cnt; b0 = dat_q.size();
    kick(16'd3);
    k = 0;
    while (dat_q.size() < b0 + 1 && k < 3000) begin
      @(negedge clk); k++;
    end
    bus.res_ready = 1'b0;
    while (bus.res_valid !== 1'b1 && k < 3000) begin
      @(negedge clk); k++;
    end
    `CHK("t3_beat1_seen", bus.res_valid, 1'b1)
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.M_AXI_arvalid !== 1'b0 ||
          bus.res_valid !== 1'b1 ||
          bus.res_data !== 14'h3FFF ||
          bus.res_index !== 16'd1)
        bad++;
    end
    `CHK("t3_stall_hold", bad, 0)
    bus.res_ready = 1'b1;
    wait_done(3000, 0, n);
    `CHK("t3_done", done, 1'b1)
    @(negedge clk);
    `CHK("t3_beats", dat_q.size() - b0, 3)
    `CHK("t3_d0", dat_q[b0], 14'd100)
    `CHK("t3_d1", dat_q[b0+1], 14'h3FFF)
    `CHK("t3_d2", dat_q[b0+2], 14'd0)
    `CHK("t3_i2", idx_q[b0+2], 16'd2)
    `CHK("t3_sum", sum, 32'd16483)
    `CHK("t3_min", min_val, 14'd0)
    `CHK("t3_max", max_val, 14'h3FFF)
    `CHK("t3_ar_stable", ar_unstable, 0)
    `CHK("t3_no_overlap", overlap, 0)
    `CHK("t3_errs", {err_resp, err_timeout}, 2'b00)
    ar_always = 1'b1;
    ar_wait = 0;

    // error response on second sample
    for (int i = 0; i < 3; i++) smp_wait[i] = 0;
    smp_data[0] = 32'd7;
    smp_data[1] = 32'd8;
    smp_data[2] = 32'd9;
    smp_resp[1] = RESP_SLVERR;
    d0 = done_cnt; b0 = dat_q.size();
    kick(16'd3);
    wait_done(200, 0, n);
    `CHK("t4_done", done, 1'b1)
    `CHK("t4_err_resp", err_resp, 1'b1)
    @(negedge clk);
    `CHK("t4_beats", dat_q.size() - b0, 1)
    `CHK("t4_sum", sum, 32'd7)
    `CHK("t4_min", min_val, 14'd7)
    `CHK("t4_max", max_val, 14'd7)
    `CHK("t4_sticky", err_resp, 1'b1)
    `CHK("t4_done_once", done_cnt - d0, 1)
    smp_resp[1] = RESP_OKAY;

    // slave withholds rvalid past the timeout
    smp_data[0] = 32'd42;
    smp_wait[0] = 630;
    d0 = done_cnt; b0 = dat_q.size();
    kick(16'd1);
    n = 0;
    while (err_timeout !== 1'b1 && n < 1000) begin
      @(negedge clk); n++;
    end
    `CHK("t5_tmo_cycle", n, 603)
    `CHK("t5_err_resp_clr", err_resp, 1'b0)
    `CHK("t5_rready", bus.M_AXI_rready, 1'b1)
    `CHK("t5_busy", busy, 1'b1)
    `CHK("t5_no_done_yet", done_cnt - d0, 0)
    wait_done(1000, n, n);
    `CHK("t5_done_cycle", n, 634)
    @(negedge clk);
    `CHK("t5_rready_off", bus.M_AXI_rready, 1'b0)
    `CHK("t5_beats", dat_q.size() - b0, 0)
    `CHK("t5_sum", sum, 32'd0)
    `CHK("t5_tmo_sticky", err_timeout, 1'b1)

    // reset in the middle of a sample read
    cfg_val = 32'd777;
    smp_wait[0] = 300;
    smp_wait[1] = 300;
    kick(16'd2);
    repeat (20) @(negedge clk);
    `CHK("t6_busy_before", busy, 1'b1)
    `CHK("t6_in_smp_r", bus.M_AXI_rready, 1'b1)
    `CHK("t6_aver_before", aver_time, 32'd777)
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    `CHK("t6_busy", busy, 1'b0)
    `CHK("t6_arvalid", bus.M_AXI_arvalid, 1'b0)
    `CHK("t6_rready", bus.M_AXI_rready, 1'b0)
    `CHK("t6_aver", aver_time, 32'd0)
    `CHK("t6_min", min_val, 14'h3FFF)
    `CHK("t6_errs", {err_resp, err_timeout}, 2'b00)
    smp_wait[0] = 0;
    smp_wait[1] = 0;
    smp_data[0] = 32'd11;
    smp_data[1] = 32'd22;
    b0 = dat_q.size();
    kick(16'd2);
    wait_done(200, 0, n);
    `CHK("t6_latency", n, 8)
    @(negedge clk);
    `CHK("t6_beats", dat_q.size() - b0, 2)
    `CHK("t6_d1", dat_q[b0+1], 14'd22)
    `CHK("t6_sum", sum, 32'd33)
    `CHK("t6_min2", min_val, 14'd11)
    `CHK("t6_max2", max_val, 14'd22)
    `CHK("t6_aver2", aver_time, 32'd777)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/probe_poll_master.md
Name: probe_poll_master

Overview:
- AXI4-Lite read-only master that drives an AXI probe detector slave from the initiator side.
- On a start command it reads the detector's averaging-window register once, then reads the probe-count register N times. Each count read stalls in the slave until a fresh measurement exists.
- Each sample goes out on a valid/ready result stream, with running sum/min/max.
- Sits in the fabric beside the detector, replacing CPU polling for autonomous characterisation sweeps.

Parameters:
- M_AXI_ADDR_WIDTH, 3, AXI address width (matches detector slave)
- M_AXI_DATA_WIDTH, 32, AXI data width
- PROBE_WIDTH, 14, valid low bits of the count register
- RESULT_ADDR, 3'h0, byte address of the probe-count register
- CONFIG_ADDR, 3'h4, byte address of the averaging-window register
- NSAMP_WIDTH, 16, width of the sample-count command
- SUM_WIDTH, 32, accumulator width
- TIMEOUT_CYCLES, 1000000, max cycles from AR accepted to R handshake

Ports:
- M_AXI_aclk  in  1  sole clock
- M_AXI_areset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle command pulse; ignored while busy
- num_samples  in  NSAMP_WIDTH  sample reads per run; sampled on accepted start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end (success or error)
- err_resp  out  1  sticky until next start: non-OKAY rresp seen
- err_timeout  out  1  sticky until next start: timeout expired
- aver_time  out  M_AXI_DATA_WIDTH  value read from CONFIG_ADDR
- sum  out  SUM_WIDTH  saturating sum of samples this run
- min_val, max_val  out  PROBE_WIDTH each  running extrema this run
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  PROBE_WIDTH  sample value
- res_index  out  NSAMP_WIDTH  0-based sample index
- M_AXI_araddr  out  M_AXI_ADDR_WIDTH  read address
- M_AXI_arprot  out  3  constant 3'b000
- M_AXI_arvalid  out  1
- M_AXI_arready  in  1
- M_AXI_rdata  in  M_AXI_DATA_WIDTH
- M_AXI_rresp  in  2
- M_AXI_rvalid  in  1
- M_AXI_rready  out  1

Behaviour:
- Reset values: all outputs 0, except min_val = all-ones. State = IDLE.
- Reset asserted mid-run: return to IDLE next edge and drop arvalid/rready. The slave shares this reset domain, so this is accepted.
- AXI rules:
  - At most one outstanding read.
  - araddr and arvalid are held stable until arready.
  - rready is asserted only in R-wait states.
  - No combinational path from any input to arvalid.
- States:
  - IDLE: on start, latch num_samples, clear sum/min/max/err/index, set busy, go CFG_AR.
  - CFG_AR: arvalid=1, araddr=CONFIG_ADDR. On arready, go CFG_R.
  - CFG_R: rready=1. On rvalid, load aver_time. If rresp≠0, set err_resp and go FIN. Else if N==0, go FIN; otherwise go SMP_AR.
  - SMP_AR: arvalid=1, araddr=RESULT_ADDR. On arready, go SMP_R.
  - SMP_R: rready=1. On rvalid, capture rdata[PROBE_WIDTH-1:0]. If rresp≠0, set err_resp and go FIN. Otherwise update sum/min/max and go PUSH.
  - PUSH: res_valid=1 with res_data and res_index stable. On res_ready, increment index; if index==N-1 go FIN, else go SMP_AR. The next AR is not issued until the push completes (backpressure stalls the bus).
  - FIN: done=1 for one cycle, busy=0, go IDLE.
- Same-cycle handshakes: arvalid&arready and rvalid&rready complete in the cycle sampled. AR→R minimum is one cycle.
- Timeout:
  - A counter clears on AR handshake and counts in CFG_R/SMP_R.
  - At TIMEOUT_CYCLES-1, set err_timeout and go DRAIN.
  - DRAIN: rready=1 until the rvalid handshake (data discarded), then go FIN. A slave that never responds is recovered only by reset.
- Arithmetic:
  - sum saturates at 2^SUM_WIDTH-1.
  - min/max compare unsigned PROBE_WIDTH values.
  - Upper rdata bits above PROBE_WIDTH are ignored.
- Latency: a run of N samples with zero-wait slave and res_ready=1 takes 2+3N+1 cycles plus slave measurement stalls.

Decomposition:
- Shared package probe_pkg:
  - state enum/localparams
  - RESULT_ADDR/CONFIG_ADDR register map
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10
- One natural sub-module, probe_stats_acc: sum/min/max accumulator with clear and update strobes.

Test Plan:
- Zero-wait slave, cfg=10000, samples 5,9,3, N=3, res_ready=1 -> three stream beats (5,0)(9,1)(3,2); sum=17, min=3, max=9, aver_time=10000; done pulse once; two araddr values seen: 4 then 0,0,0.
- N=0 -> only CFG read issued; done one cycle after R; no res_valid.
- Slave delays rvalid 500 cycles per sample, res_ready low 20 cycles on beat 1 -> arvalid stays 0 during the stall; indices and values in order; arvalid/araddr stable until arready.
- rresp=SLVERR on second sample -> err_resp=1; no push for that beat; done asserted; sum holds only the first sample.
- TIMEOUT_CYCLES=50, slave withholds rvalid 80 cycles -> err_timeout at cycle 50; rready held until the late rvalid; then done.
- Reset asserted during SMP_R, then start again -> all outputs back to reset values; new run completes correctly.
